// File: rtl/drop_scheduler_if.sv
// Timer / game-FSM side signals of the gravity drop scheduler.
interface drop_scheduler_if #(
    parameter int unsigned TOP_WIDTH = 25
);
    logic                 tick_in;
    logic                 pause;
    logic                 soft_drop;
    logic                 lines_valid;
    logic [2:0]           lines_count;
    logic                 drop_ack;
    logic [TOP_WIDTH-1:0] top_out;
    logic                 drop_req;
    logic [3:0]           level;
    logic [9:0]           lines_total;
    logic                 overrun;

    // Scheduler side.
    modport slave (
        input  tick_in, pause, soft_drop, lines_valid, lines_count, drop_ack,
        output top_out, drop_req, level, lines_total, overrun
    );

    // Environment side (timer, game FSM, line-clear logic).
    modport master (
        output tick_in, pause, soft_drop, lines_valid, lines_count, drop_ack,
        input  top_out, drop_req, level, lines_total, overrun
    );
endinterface

// File: rtl/drop_scheduler.sv
// Gravity / drop-rate controller: turns timer ticks into a held drop request,
// counts cleared lines, advances the level and drives the timer period.
module drop_scheduler #(
    parameter int unsigned TOP_WIDTH       = 25,
    parameter int unsigned BASE_TOP        = 12000000,
    parameter int unsigned STEP            = 1000000,
    parameter int unsigned MIN_TOP         = 1500000,
    parameter int unsigned SOFT_TOP        = 1200000,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    drop_scheduler_if.slave  bus
);

    localparam logic [3:0] LPL4  = 4'(LINES_PER_LEVEL);
    localparam logic [3:0] MAXL4 = 4'(MAX_LEVEL);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_overrun;
    logic                 w_overrun_nxt;
    logic                 w_tick;

    logic [3:0]           r_level;
    logic [3:0]           r_acc;
    logic [9:0]           r_total;
    logic [2:0]           w_n;
    logic [10:0]          w_total_sum;
    logic [3:0]           w_acc_sum;

    logic [31:0]          w_dec;
    logic [31:0]          w_norm;
    logic [31:0]          w_tgt;
    logic [TOP_WIDTH-1:0] r_top;

    assign w_tick = bus.tick_in & ~bus.pause;

    // Drop-request state and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_state   <= S_IDLE;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Next request state: a new tick wins over an ack in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_overrun_nxt = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (w_tick) begin
                    w_state_nxt = S_PEND;
                    if (!bus.drop_ack) begin
                        w_overrun_nxt = 1'b1;
                    end
                end else if (bus.drop_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clamped line count and the sums it feeds.
    always_comb begin
        w_n         = (bus.lines_count > 3'd4) ? 3'd4 : bus.lines_count;
        w_total_sum = {1'b0, r_total} + {8'b0, w_n};
        w_acc_sum   = r_acc + {1'b0, w_n};
    end

    // Line total, level accumulator and level; at most one level per strobe.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_total <= '0;
            r_acc   <= '0;
            r_level <= '0;
        end else if (bus.lines_valid) begin
            r_total <= (w_total_sum > 11'd1023) ? 10'd1023 : w_total_sum[9:0];
            if (w_acc_sum >= LPL4) begin
                r_acc <= w_acc_sum - LPL4;
                if (r_level < MAXL4) begin
                    r_level <= r_level + 4'd1;
                end
            end else begin
                r_acc <= w_acc_sum;
            end
        end
    end

    // Level-derived period with floor, then the soft-drop ceiling.
    always_comb begin
        w_dec = 32'(r_level) * STEP;
        if (w_dec > BASE_TOP) begin
            w_norm = MIN_TOP;
        end else begin
            w_norm = BASE_TOP - w_dec;
            if (w_norm < MIN_TOP) begin
                w_norm = MIN_TOP;
            end
        end
        w_tgt = (bus.soft_drop && (w_norm > SOFT_TOP)) ? SOFT_TOP : w_norm;
    end

    // Registered period to the timer.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_top <= TOP_WIDTH'(BASE_TOP);
        end else begin
            r_top <= TOP_WIDTH'(w_tgt);
        end
    end

    assign bus.top_out     = r_top;
    assign bus.drop_req    = (r_state == S_PEND);
    assign bus.level       = r_level;
    assign bus.lines_total = r_total;
    assign bus.overrun     = r_overrun;

endmodule

// File: doc/drop_scheduler.md
Name: drop_scheduler

Overview:
- Gravity/drop-rate controller; sits at the consumer end of the tick timer.
- Drives the timer's period value (top_out) from current level and soft-drop state.
- Consumes the timer's single-cycle trigger pulses and converts each into a held drop request, handshaken with the game FSM.
- Tracks total lines cleared and advances the level every LINES_PER_LEVEL lines.

Parameters:
- TOP_WIDTH, 25, width of the period value driven to the timer.
- BASE_TOP, 12000000, period at level 0.
- STEP, 1000000, period reduction per level.
- MIN_TOP, 1500000, floor for the level-derived period.
- SOFT_TOP, 1200000, period ceiling while soft_drop is asserted.
- LINES_PER_LEVEL, 10, lines needed per level increment.
- MAX_LEVEL, 15, level saturation value; must fit in 4 bits.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-low.
- clear, in, 1, synchronous game restart; same effect as reset on all state.
- tick_in, in, 1, single-cycle trigger from the timer.
- pause, in, 1, masks tick_in while high.
- soft_drop, in, 1, player soft-drop held.
- lines_valid, in, 1, one-cycle strobe accompanying lines_count.
- lines_count, in, 3, lines cleared by the last lock (0..4).
- drop_ack, in, 1, game FSM consumed the drop request.
- top_out, out, TOP_WIDTH, period to the timer.
- drop_req, out, 1, pending gravity drop.
- level, out, 4, current level.
- lines_total, out, 10, total lines cleared; saturates at 1023.
- overrun, out, 1, sticky: a tick arrived while a request was still pending.

Behaviour:
- Reset (reset==0 at a clk edge) or clear==1:
  - top_out=BASE_TOP, drop_req=0, level=0, lines_total=0, overrun=0, internal line accumulator=0.
  - reset has priority over all inputs.
- Drop request handshake, evaluated each cycle:
  - Let t = tick_in & ~pause.
  - If t: drop_req<=1 next cycle. If drop_req==1 and drop_ack==0 in the same cycle, overrun<=1. The tick is collapsed, never queued.
  - Else if drop_ack & drop_req: drop_req<=0.
  - drop_ack and t in the same cycle: drop_req stays 1, overrun not set.
  - drop_ack while drop_req==0: ignored.
  - pause does not clear a pending drop_req; it only masks new ticks.
  - Latency from tick_in to drop_req: 1 cycle.
- Line accounting, on lines_valid:
  - n = min(lines_count, 4). Values 5..7 are clamped to 4.
  - lines_total <= min(lines_total+n, 1023).
  - acc_new = acc + n (4-bit accumulator, max 13).
  - If acc_new >= LINES_PER_LEVEL: acc <= acc_new - LINES_PER_LEVEL and level <= min(level+1, MAX_LEVEL). Otherwise acc <= acc_new.
  - At most one level increment per strobe.
  - At MAX_LEVEL the accumulator still counts and wraps; level holds.
  - lines_valid==1 with n==0: no state change.
- Period computation:
  - norm = BASE_TOP - level*STEP, computed signed or with guard.
  - If BASE_TOP < level*STEP, or norm < MIN_TOP, then norm = MIN_TOP.
  - tgt = soft_drop ? min(norm, SOFT_TOP) : norm.
  - top_out <= tgt, registered.
  - top_out reflects a level change 1 cycle after level updates, i.e. 2 cycles after lines_valid.
  - top_out reflects a soft_drop change 1 cycle after it.
  - The multiply may be replaced by a running subtract register; the cycle timing above must be preserved.
- overrun clears only on reset or clear.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset then idle 20 cycles -> top_out=12000000, level=0, drop_req=0, overrun=0.
- tick_in pulse at cycle 5, drop_ack at cycle 9 -> drop_req high cycles 6..9, low at 10; overrun=0.
- Second tick while drop_req pending, no ack -> overrun=1 and stays 1. Repeat with tick and ack in the same cycle -> drop_req stays 1, overrun unchanged.
- lines_valid with counts 4,4,3 -> lines_total=11, level=1, top_out=11000000 two cycles after the third strobe. A further 4,4,4,4,4,4,4 -> lines_total=39, level=3, top_out=9000000.
- Drive 12 levels via repeated 4-line strobes -> top_out floors at 1500000 from level 11. Level saturates at 15. lines_total saturates at 1023 after 256 strobes of 4.
- soft_drop=1 at level 0 -> top_out=1200000 next cycle; release -> 12000000. pause=1 with tick_in pulses -> no drop_req. Assert clear mid-request -> all outputs return to reset values.
